wb_arbiter: RTL and testbench

- Write-back arbiter on the producer side of the integer register file. Merges ALU and load-store-unit results into the single register-file write port: reg_write, rd, rslt_data.
- Keeps a per-register pending-load scoreboard.
- Gives decode a busy flag for each of rs1 and rs2, so decode stalls instead of reading stale register-file data.

---
 rtl/wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and load results onto the register-file write port,
// tracks outstanding loads, and reports source busy flags. Optional macro: WB_BYPASS_EN.
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [RW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [RW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            ld_issue,
    input  logic [RW-1:0]   ld_rd,
    input  logic [RW-1:0]   rs1,
    input  logic [RW-1:0]   rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
`ifdef WB_BYPASS_EN
    output logic            fwd1_valid,
    output logic [XLEN-1:0] fwd1_data,
    output logic            fwd2_valid,
    output logic [XLEN-1:0] fwd2_data,
`endif
    output logic            reg_write,
    output logic [RW-1:0]   rd,
    output logic [XLEN-1:0] rslt_data
);

    localparam logic [RW-1:0] ZERO_IDX = {RW{1'b0}};

    logic            skid_full_r;
    logic [RW-1:0]   skid_rd_r;
    logic [XLEN-1:0] skid_data_r;
    logic [NREG-1:0] pending_r;

    logic            alu_xfer_s;
    logic            lsu_xfer_s;
    logic            sel_s;
    logic [RW-1:0]   sel_rd_s;
    logic [XLEN-1:0] sel_data_s;
    logic            skid_load_s;
    logic [NREG-1:0] pending_s;
    logic            inflight1_s;
    logic            inflight2_s;

    // Readies depend only on skid occupancy; reset forces them low.
    always_comb begin
        alu_ready  = rst_n & ~skid_full_r;
        lsu_ready  = rst_n & ~skid_full_r;
        alu_xfer_s = alu_valid & alu_ready;
        lsu_xfer_s = lsu_valid & lsu_ready;
    end

    // Write selection: a parked ALU result drains first, then LSU beats ALU.
    always_comb begin
        sel_s       = 1'b0;
        sel_rd_s    = skid_rd_r;
        sel_data_s  = skid_data_r;
        skid_load_s = 1'b0;
        if (skid_full_r) begin
            sel_s = 1'b1;
        end else if (lsu_xfer_s) begin
            sel_s       = 1'b1;
            sel_rd_s    = lsu_rd;
            sel_data_s  = lsu_data;
            skid_load_s = alu_xfer_s;
        end else if (alu_xfer_s) begin
            sel_s      = 1'b1;
            sel_rd_s   = alu_rd;
            sel_data_s = alu_data;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Pending-load update; a same-cycle issue overrides the completing load.
    always_comb begin
        pending_s = pending_r;
        if (lsu_xfer_s && (lsu_rd != ZERO_IDX)) begin
            pending_s[lsu_rd] = 1'b0;
        end else begin
            pending_s = pending_s;
        end
        if (ld_issue && (ld_rd != ZERO_IDX)) begin
            pending_s[ld_rd] = 1'b1;
        end else begin
            pending_s = pending_s;
        end
        pending_s[0] = 1'b0;
    end

    // Skid buffer, scoreboard and registered write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_full_r <= 1'b0;
            skid_rd_r   <= ZERO_IDX;
            skid_data_r <= {XLEN{1'b0}};
            pending_r   <= {NREG{1'b0}};
            reg_write   <= 1'b0;
            rd          <= ZERO_IDX;
            rslt_data   <= {XLEN{1'b0}};
        end else begin
            pending_r <= pending_s;
            if (skid_load_s) begin
                skid_full_r <= 1'b1;
                skid_rd_r   <= alu_rd;
                skid_data_r <= alu_data;
            end else if (skid_full_r) begin
                skid_full_r <= 1'b0;
            end
            reg_write <= sel_s && (sel_rd_s != ZERO_IDX);
            if (sel_s) begin
                rd        <= sel_rd_s;
                rslt_data <= sel_data_s;
            end
        end
    end

    // Source busy flags; with bypass the in-flight write is forwarded instead.
    always_comb begin
`ifdef WB_BYPASS_EN
        inflight1_s = 1'b0;
        inflight2_s = 1'b0;
        fwd1_valid  = (rs1 != ZERO_IDX) && reg_write && (rd == rs1);
        fwd2_valid  = (rs2 != ZERO_IDX) && reg_write && (rd == rs2);
        fwd1_data   = rslt_data;
        fwd2_data   = rslt_data;
`else
        inflight1_s = reg_write && (rd == rs1);
        inflight2_s = reg_write && (rd == rs2);
`endif
        if (rs1 != ZERO_IDX) begin
            rs1_busy = pending_r[rs1] || (skid_full_r && (skid_rd_r == rs1)) || inflight1_s;
        end else begin
            rs1_busy = 1'b0;
        end
        if (rs2 != ZERO_IDX) begin
            rs2_busy = pending_r[rs2] || (skid_full_r && (skid_rd_r == rs2)) || inflight2_s;
        end else begin
            rs2_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes are queued by stimulus and
// popped by a negedge monitor whenever reg_write is high.
module tb_wb_arbiter;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid, lsu_valid, ld_issue;
    logic            alu_ready, lsu_ready;
    logic [RW-1:0]   alu_rd, lsu_rd, ld_rd, rs1, rs2;
    logic [XLEN-1:0] alu_data, lsu_data;
    logic            rs1_busy, rs2_busy, reg_write;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] rslt_data;
`ifdef WB_BYPASS_EN
    logic            fwd1_valid, fwd2_valid;
    logic [XLEN-1:0] fwd1_data, fwd2_data;
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [RW+XLEN-1:0] exp_q[$];

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .ld_issue(ld_issue), .ld_rd(ld_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef WB_BYPASS_EN
        .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
        .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data),
`endif
        .reg_write(reg_write), .rd(rd), .rslt_data(rslt_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h expected none", rd, rslt_data);
            end else begin
                check("write", {27'd0, rd, rslt_data}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; ld_issue = 1'b0;
        alu_rd = 5'd0; lsu_rd = 5'd0; ld_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        alu_data = 32'd0; lsu_data = 32'd0;
        tick(); tick();
        check("rst_reg_write", {63'd0, reg_write}, 64'd0);
        check("rst_rd", {59'd0, rd}, 64'd0);
        check("rst_data", {32'd0, rslt_data}, 64'd0);
        check("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
        check("rst_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {62'd0, alu_ready, lsu_ready}, 64'd3);

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        exp_q.push_back({5'd5, 32'h1234});
        tick();
        alu_valid = 1'b0;
        check("alu_only_ready", {63'd0, alu_ready}, 64'd1);
        tick();

        // Collision: LSU first, ALU parked one cycle
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hAAAA;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hBBBB;
        exp_q.push_back({5'd3, 32'hAAAA});
        exp_q.push_back({5'd4, 32'hBBBB});
        tick();
        lsu_valid = 1'b0; alu_valid = 1'b0;
        check("coll_ready_low", {62'd0, alu_ready, lsu_ready}, 64'd0);
        tick();
        tick();
        check("coll_ready_back", {62'd0, alu_ready, lsu_ready}, 64'd3);

        // Scoreboard on rs1=7
        ld_issue = 1'b1; ld_rd = 5'd7; rs1 = 5'd7;
        tick();
        ld_issue = 1'b0;
        check("sb_busy_issued", {63'd0, rs1_busy}, 64'd1);
        tick();
        check("sb_busy_wait", {63'd0, rs1_busy}, 64'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h7777;
        exp_q.push_back({5'd7, 32'h7777});
        tick();
        lsu_valid = 1'b0;
        check("sb_busy_inflight", {63'd0, rs1_busy}, {63'd0, ~BYP});
`ifdef WB_BYPASS_EN
        check("sb_fwd1", {31'd0, fwd1_valid, fwd1_data}, {31'd0, 1'b1, 32'h7777});
`endif
        tick();
        check("sb_busy_clear", {63'd0, rs1_busy}, 64'd0);

        // x0 destination and x0 load
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        ld_issue = 1'b1; ld_rd = 5'd0; rs1 = 5'd0;
        tick();
        alu_valid = 1'b0; ld_issue = 1'b0;
        check("x0_no_write", {63'd0, reg_write}, 64'd0);
        check("x0_data_upd", {27'd0, rd, rslt_data}, {27'd0, 5'd0, 32'hFFFF});
        check("x0_rs1_busy", {63'd0, rs1_busy}, 64'd0);
        tick();
        check("x0_rs1_busy2", {63'd0, rs1_busy}, 64'd0);

        // Same-cycle set/clear on register 9
        ld_issue = 1'b1; ld_rd = 5'd9; rs2 = 5'd9;
        tick();
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999;
        exp_q.push_back({5'd9, 32'h9999});
        tick();
        lsu_valid = 1'b0; ld_issue = 1'b0;
        check("sc_busy", {63'd0, rs2_busy}, 64'd1);
        tick();
        tick();
        check("sc_still_pending", {63'd0, rs2_busy}, 64'd1);
        lsu_valid = 1'b1; lsu_data = 32'h0909;
        exp_q.push_back({5'd9, 32'h0909});
        tick();
        lsu_valid = 1'b0;
        tick();
        check("sc_released", {63'd0, rs2_busy}, 64'd0);

        // Reset while skid holds ALU result for x11
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA10;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB11;
        rs2 = 5'd11;
        exp_q.push_back({5'd10, 32'hA10});
        tick();
        lsu_valid = 1'b0; alu_valid = 1'b0;
        check("rc_skid_busy", {63'd0, rs2_busy}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rc_ready_in_rst", {62'd0, alu_ready, lsu_ready}, 64'd0);
        tick();
        check("rc_no_write", {63'd0, reg_write}, 64'd0);
        check("rc_ready_in_rst2", {62'd0, alu_ready, lsu_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rc_ready_after", {62'd0, alu_ready, lsu_ready}, 64'd3);
        check("rc_skid_dropped", {63'd0, rs2_busy}, 64'd0);
        tick();
        check("rc_no_parked", {63'd0, reg_write}, 64'd0);
        tick();
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
